// File: rtl/morse_pkg.sv
// Shared types and helpers for the Morse character sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SGAP  = 3'd3,
    ST_LGAP  = 3'd4
  } state_e;

  localparam int unsigned MAX_SYM_DEF = 4;
  localparam logic        SYM_DOT     = 1'b0;
  localparam logic        SYM_DASH    = 1'b1;

  // Lengths beyond the pattern width are treated as a full-width character.
  function automatic logic [2:0] clamp_len(input logic [2:0] len, input int unsigned max_sym);
    if (32'(len) > max_sym) return 3'(max_sym);
    return len;
  endfunction

endpackage

// File: rtl/morse_gap_timer.sv
// Loadable down-counter; saturates at zero, flags expiry on its final counted cycle.
module morse_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q <= W'(1));

endmodule

// File: rtl/morse_char_seq.sv
// Character sequencer: issues each symbol to led_fsm, waits for completion, inserts gaps.
module morse_char_seq
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYM    = MAX_SYM_DEF,
  parameter int unsigned SYM_GAP    = 1,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned WORD_GAP   = 7,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               char_valid,
  output logic               char_ready,
  input  logic [2:0]         char_len,
  input  logic [MAX_SYM-1:0] char_pat,
  output logic               sym_strt,
  output logic               symbol,
  input  logic               sym_done,
  output logic               char_done,
  output logic               seq_err,
  output logic               busy
);

  localparam int unsigned GAP_MAX = (WORD_GAP > TIMEOUT) ? WORD_GAP : TIMEOUT;
  localparam int unsigned CW      = $clog2(GAP_MAX + 1);

  state_e             state_q;
  logic [MAX_SYM-1:0] shreg_q;
  logic [2:0]         rem_q;
  logic               ready_q, busy_q, sym_strt_q, symbol_q, char_done_q, seq_err_q;

  logic [2:0]         len_c;
  logic               tmr_load_d;
  logic [CW-1:0]      tmr_val_d;
  logic               tmr_exp;

  assign len_c = clamp_len(char_len, MAX_SYM);

  // The one timer serves the gaps and, reloaded on every ISSUE, the sym_done watchdog.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    case (state_q)
      ST_IDLE: if (char_valid && len_c == 3'd0) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = CW'(WORD_GAP);
      end
      ST_ISSUE: begin
        tmr_load_d = 1'b1;
        tmr_val_d  = CW'(TIMEOUT);
      end
      ST_WAIT: if (sym_done) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = (rem_q != 3'd0) ? CW'(SYM_GAP) : CW'(LETTER_GAP);
      end
      default: ;
    endcase
  end

  morse_gap_timer #(.W(CW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load_d),
    .value   (tmr_val_d),
    .expired (tmr_exp)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      sym_strt_q  <= 1'b0;
      symbol_q    <= SYM_DOT;
      char_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      sym_strt_q  <= 1'b0;
      char_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (char_valid) begin
          shreg_q <= char_pat;
          rem_q   <= len_c;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          if (len_c == 3'd0) begin
            state_q <= ST_LGAP;
          end else begin
            state_q    <= ST_ISSUE;
            sym_strt_q <= 1'b1;
            symbol_q   <= char_pat[MAX_SYM-1];
          end
        end
        ST_ISSUE: begin
          shreg_q  <= shreg_q << 1;
          rem_q    <= rem_q - 3'd1;
          symbol_q <= SYM_DOT;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sym_done) begin
            state_q <= (rem_q != 3'd0) ? ST_SGAP : ST_LGAP;
          end else if (tmr_exp) begin
            state_q   <= ST_IDLE;
            seq_err_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        ST_SGAP: if (tmr_exp) begin
          state_q    <= ST_ISSUE;
          sym_strt_q <= 1'b1;
          symbol_q   <= shreg_q[MAX_SYM-1];
        end
        ST_LGAP: if (tmr_exp) begin
          state_q     <= ST_IDLE;
          char_done_q <= 1'b1;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign sym_strt   = sym_strt_q;
  assign symbol     = symbol_q;
  assign char_done  = char_done_q;
  assign seq_err    = seq_err_q;

endmodule
